// File: rtl/registro_desplazamiento.sv
// registro_desplazamiento: WIDTH-bit universal shift register with hold, parallel
// load, logical shift, rotate and clear. Also provides a serial output of the last
// bit shifted out, and a saturating shift counter with an empty flag.
module registro_desplazamiento #(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
  localparam int                CNT_W       = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              sin,
  output logic [WIDTH-1:0]  q,
  output logic              sout,
  output logic [CNT_W-1:0]  cnt,
  output logic              empty
);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_LOAD  = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_SHR   = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_ROR   = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_RSVD  = 3'b111
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  logic [WIDTH-1:0] r_q;
  logic             r_sout;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_sout_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Counter stops at WIDTH so the empty flag stays up under further shifts
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_FULL) ? c : c + CNT_W'(1);
  endfunction

  // Next-state decode for every mode; reserved encoding falls through to hold
  always_comb begin
    w_q_nxt    = r_q;
    w_sout_nxt = r_sout;
    w_cnt_nxt  = r_cnt;
    case (mode)
      MODE_LOAD: begin
        w_q_nxt   = d;
        w_cnt_nxt = '0;
      end
      MODE_SHL: begin
        w_q_nxt    = {r_q[WIDTH-2:0], sin};
        w_sout_nxt = r_q[WIDTH-1];
        w_cnt_nxt  = sat_inc(r_cnt);
      end
      MODE_SHR: begin
        w_q_nxt    = {sin, r_q[WIDTH-1:1]};
        w_sout_nxt = r_q[0];
        w_cnt_nxt  = sat_inc(r_cnt);
      end
      MODE_ROL: begin
        w_q_nxt    = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_sout_nxt = r_q[WIDTH-1];
      end
      MODE_ROR: begin
        w_q_nxt    = {r_q[0], r_q[WIDTH-1:1]};
        w_sout_nxt = r_q[0];
      end
      MODE_CLEAR: begin
        w_q_nxt    = '0;
        w_sout_nxt = 1'b0;
        w_cnt_nxt  = '0;
      end
      default: begin
        w_q_nxt    = r_q;
        w_sout_nxt = r_sout;
        w_cnt_nxt  = r_cnt;
      end
    endcase
  end

  // State register; reset overrides any mode on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q    <= RESET_VALUE;
      r_sout <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_q    <= w_q_nxt;
      r_sout <= w_sout_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign q     = r_q;
  assign sout  = r_sout;
  assign cnt   = r_cnt;
  assign empty = (r_cnt == CNT_FULL);

endmodule

// File: tb/tb_registro_desplazamiento.sv
// Testbench for registro_desplazamiento with WIDTH = 4, RESET_VALUE = 4'b1010.
module tb_registro_desplazamiento;

  localparam int WIDTH = 4;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk;
  logic             reset;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic [CNT_W-1:0] cnt;
  logic             empty;

  int checks;
  int errors;

  // Reference model state as plain integers
  int m_q;
  int m_sout;
  int m_cnt;

  registro_desplazamiento #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (4'b1010)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .mode  (mode),
    .d     (d),
    .sin   (sin),
    .q     (q),
    .sout  (sout),
    .cnt   (cnt),
    .empty (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge, then settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mode = 3'b001; d = 4'b1111; sin = 1'b1;
    tick();
    tick();
    checks++; if (q !== 4'b1010) begin errors++; $display("FAIL reset_q: got %b required %b", q, 4'b1010); end
    checks++; if (sout !== 1'b0) begin errors++; $display("FAIL reset_sout: got %b required 0", sout); end
    checks++; if (cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d required 0", cnt); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL reset_empty: got %b required 0", empty); end
    reset = 1'b0; mode = 3'b000;
    tick();
    checks++; if (q !== 4'b1010) begin errors++; $display("FAIL release_hold_q: got %b required %b", q, 4'b1010); end
  endtask

  task automatic test_load_shl();
    logic [3:0] exp_q [4];
    logic       exp_s [4];
    exp_q = '{4'b1101, 4'b1011, 4'b0111, 4'b1111};
    exp_s = '{1'b0, 1'b1, 1'b1, 1'b0};
    mode = 3'b001; d = 4'b0110;
    tick();
    checks++; if (q !== 4'b0110 || cnt !== 3'd0) begin errors++; $display("FAIL load_0110: got q=%b cnt=%0d required q=0110 cnt=0", q, cnt); end
    mode = 3'b010; sin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (q !== exp_q[i]) begin errors++; $display("FAIL shl_q[%0d]: got %b required %b", i, q, exp_q[i]); end
      checks++; if (sout !== exp_s[i]) begin errors++; $display("FAIL shl_sout[%0d]: got %b required %b", i, sout, exp_s[i]); end
      checks++; if (cnt !== 3'(i + 1)) begin errors++; $display("FAIL shl_cnt[%0d]: got %0d required %0d", i, cnt, i + 1); end
      checks++; if (empty !== (i == 3)) begin errors++; $display("FAIL shl_empty[%0d]: got %b required %b", i, empty, (i == 3)); end
    end
  endtask

  task automatic test_saturation();
    mode = 3'b010; sin = 1'b0;
    tick();
    checks++; if (q !== 4'b1110) begin errors++; $display("FAIL sat_q: got %b required 1110", q); end
    checks++; if (sout !== 1'b1) begin errors++; $display("FAIL sat_sout: got %b required 1", sout); end
    checks++; if (cnt !== 3'd4) begin errors++; $display("FAIL sat_cnt: got %0d required 4", cnt); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL sat_empty: got %b required 1", empty); end
    mode = 3'b001; d = 4'b0001;
    tick();
    checks++; if (cnt !== 3'd0 || empty !== 1'b0) begin errors++; $display("FAIL sat_reload: got cnt=%0d empty=%b required cnt=0 empty=0", cnt, empty); end
    checks++; if (q !== 4'b0001) begin errors++; $display("FAIL sat_reload_q: got %b required 0001", q); end
  endtask

  task automatic test_shr_rotate();
    mode = 3'b001; d = 4'b1001;
    tick();
    mode = 3'b011; sin = 1'b0;
    tick();
    checks++; if (q !== 4'b0100 || sout !== 1'b1 || cnt !== 3'd1) begin errors++; $display("FAIL shr: got q=%b sout=%b cnt=%0d required q=0100 sout=1 cnt=1", q, sout, cnt); end
    mode = 3'b101;
    tick();
    checks++; if (q !== 4'b0010 || sout !== 1'b0 || cnt !== 3'd1) begin errors++; $display("FAIL ror: got q=%b sout=%b cnt=%0d required q=0010 sout=0 cnt=1", q, sout, cnt); end
    mode = 3'b100;
    tick();
    checks++; if (q !== 4'b0100 || sout !== 1'b0 || cnt !== 3'd1) begin errors++; $display("FAIL rol: got q=%b sout=%b cnt=%0d required q=0100 sout=0 cnt=1", q, sout, cnt); end
    // Rotate with a one in the MSB so sout and wraparound are both exercised
    mode = 3'b001; d = 4'b1000;
    tick();
    mode = 3'b100;
    tick();
    checks++; if (q !== 4'b0001 || sout !== 1'b1) begin errors++; $display("FAIL rol_wrap: got q=%b sout=%b required q=0001 sout=1", q, sout); end
    mode = 3'b101;
    tick();
    checks++; if (q !== 4'b1000 || sout !== 1'b1) begin errors++; $display("FAIL ror_wrap: got q=%b sout=%b required q=1000 sout=1", q, sout); end
  endtask

  task automatic test_clear_reserved();
    mode = 3'b001; d = 4'b1001;
    tick();
    mode = 3'b011; sin = 1'b0;
    tick();
    // q = 0100, sout = 1, cnt = 1
    mode = 3'b111; d = 4'b1111; sin = 1'b1;
    tick();
    checks++; if (q !== 4'b0100 || sout !== 1'b1 || cnt !== 3'd1) begin errors++; $display("FAIL reserved: got q=%b sout=%b cnt=%0d required q=0100 sout=1 cnt=1", q, sout, cnt); end
    mode = 3'b000;
    tick();
    checks++; if (q !== 4'b0100 || sout !== 1'b1 || cnt !== 3'd1) begin errors++; $display("FAIL hold: got q=%b sout=%b cnt=%0d required q=0100 sout=1 cnt=1", q, sout, cnt); end
    mode = 3'b110;
    tick();
    checks++; if (q !== 4'b0000 || sout !== 1'b0 || cnt !== 3'd0) begin errors++; $display("FAIL clear: got q=%b sout=%b cnt=%0d required q=0000 sout=0 cnt=0", q, sout, cnt); end
  endtask

  task automatic test_reset_mid();
    mode = 3'b001; d = 4'b1111;
    tick();
    mode = 3'b010; sin = 1'b0;
    tick();
    tick();
    checks++; if (q !== 4'b1100 || cnt !== 3'd2) begin errors++; $display("FAIL mid_pre: got q=%b cnt=%0d required q=1100 cnt=2", q, cnt); end
    reset = 1'b1; mode = 3'b010;
    tick();
    checks++; if (q !== 4'b1010 || cnt !== 3'd0 || sout !== 1'b0) begin errors++; $display("FAIL mid_reset: got q=%b cnt=%0d sout=%b required q=1010 cnt=0 sout=0", q, cnt, sout); end
    reset = 1'b0; mode = 3'b010; sin = 1'b1;
    tick();
    checks++; if (q !== 4'b0101 || cnt !== 3'd1 || sout !== 1'b1) begin errors++; $display("FAIL mid_release: got q=%b cnt=%0d sout=%b required q=0101 cnt=1 sout=1", q, cnt, sout); end
  endtask

  // Reference model: register contents treated as an integer 0..15
  task automatic model_step(input bit rst, input int m, input int dv, input int s);
    if (rst) begin
      m_q = 10; m_sout = 0; m_cnt = 0;
    end else begin
      case (m)
        1: begin m_q = dv; m_cnt = 0; end
        2: begin m_sout = m_q / 8; m_q = (m_q * 2 + s) % 16; m_cnt = (m_cnt < 4) ? m_cnt + 1 : 4; end
        3: begin m_sout = m_q % 2; m_q = m_q / 2 + s * 8; m_cnt = (m_cnt < 4) ? m_cnt + 1 : 4; end
        4: begin m_sout = m_q / 8; m_q = (m_q * 2) % 16 + m_q / 8; end
        5: begin m_sout = m_q % 2; m_q = m_q / 2 + (m_q % 2) * 8; end
        6: begin m_q = 0; m_sout = 0; m_cnt = 0; end
        default: ;
      endcase
    end
  endtask

  task automatic test_random();
    bit r;
    int m, dv, s;
    reset = 1'b1; mode = 3'b000;
    tick();
    model_step(1'b1, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 24) == 0);
      // Bias toward shifts so the counter regularly saturates
      m  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(2, 3);
      if ($urandom_range(0, 9) == 0) m = 1;
      dv = $urandom_range(0, 15);
      s  = $urandom_range(0, 1);
      reset = r; mode = 3'(m); d = 4'(dv); sin = s[0];
      tick();
      model_step(r, m, dv, s);
      checks++;
      if (q !== 4'(m_q) || sout !== m_sout[0] || cnt !== 3'(m_cnt) || empty !== (m_cnt == 4)) begin
        errors++;
        $display("FAIL random[%0d] mode=%0d rst=%0d: got q=%b sout=%b cnt=%0d empty=%b required q=%b sout=%0d cnt=%0d empty=%0d",
                 i, m, r, q, sout, cnt, empty, 4'(m_q), m_sout, m_cnt, (m_cnt == 4));
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    mode  = 3'bxxx;
    d     = 'x;
    sin   = 1'bx;
    #2;
    test_reset();
    test_load_shl();
    test_saturation();
    test_shr_rotate();
    test_clear_reserved();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/registro_desplazamiento.md
# registro_desplazamiento

Parametrised universal shift register. Generalises the single-bit D flip-flop to a WIDTH-bit register with hold, parallel load, logical shift, rotate and clear modes. Adds serial in/out and a shift counter with an empty flag, so it can act as a serializer/deserializer stage in the lab datapath exercises. Fully synchronous: one clock and a synchronous active-high reset.

## Interface
- WIDTH, default 8: register width in bits; legal range 2..32.
- RESET_VALUE, default 0: value loaded into q on reset, WIDTH bits.
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk and overrides every other input.
- mode  input  3  operation select, sampled on the rising edge of clk.
- d  input  WIDTH  parallel load data.
- sin  input  1  serial input bit for logical shifts.
- q  output  WIDTH  register contents.
- sout  output  1  registered copy of the last bit shifted out.
- cnt  output  $clog2(WIDTH+1)  number of logical shifts since the last load or clear; saturates at WIDTH.
- empty  output  1  high when cnt == WIDTH.

## Operation
- Reset on a rising edge: q = RESET_VALUE, sout = 0, cnt = 0, empty = 0. Reset takes priority over mode.
- Mode encoding, applied on each rising edge when reset = 0:
  - 000 hold: q, sout and cnt are unchanged.
  - 001 load: q = d, cnt = 0, sout is unchanged.
  - 010 shl: q = {q[WIDTH-2:0], sin}, sout = old q[WIDTH-1], cnt increments by 1.
  - 011 shr: q = {sin, q[WIDTH-1:1]}, sout = old q[0], cnt increments by 1.
  - 100 rol: q = {q[WIDTH-2:0], q[WIDTH-1]}, sout = old q[WIDTH-1], cnt is unchanged.
  - 101 ror: q = {q[0], q[WIDTH-1:1]}, sout = old q[0], cnt is unchanged.
  - 110 clear: q = 0, sout = 0, cnt = 0.
  - 111 reserved: behaves as hold.
- cnt saturates. A shift while cnt == WIDTH still shifts q and updates sout, but cnt stays at WIDTH.
- empty is a combinational decode of registered cnt and has no extra delay.
- The width of cnt must hold the value WIDTH (for example, 4 bits when WIDTH = 8).
- q is never X after the first reset edge. The mode, d and sin values present before any reset must not cause X on q once reset has been applied.

## Timing
- q, sout and cnt take effect on the same rising edge that samples mode. Latency is 1 cycle from input to output.
- empty is valid in the same cycle as cnt.
- Back-to-back operations of any mode are accepted every cycle. There are no handshake or stall conditions.
- Load and shift are mutually exclusive by encoding, so no simultaneous-event arbitration is needed.
- Reset asserted mid-sequence, for example after 3 of 8 shifts: the next edge forces reset values, and the prior count is discarded.
- Reset held for multiple cycles keeps all outputs at their reset values.
- Deassertion of reset: the first edge with reset = 0 executes mode normally.

## Test plan
Use WIDTH = 4 and RESET_VALUE = 4'b1010 unless stated otherwise.
- Reset: assert reset for 2 edges with mode = 001 and d = 4'b1111 -> q = 1010, sout = 0, cnt = 0, empty = 0. On the first edge after release with mode = 000 -> q = 1010.
- Load then shl with sin = 1 for 4 cycles after loading d = 0110 -> q sequence 1101, 1011, 0111, 1111. sout sequence 0, 1, 1, 0. cnt sequence 1, 2, 3, 4. empty = 1 after the 4th edge.
- Saturation: from the previous state, one more shl with sin = 0 -> q = 1110, sout = 1, cnt stays 4, empty stays 1. A subsequent load of d = 0001 -> cnt = 0, empty = 0.
- Shift right and rotates: load 1001, then shr with sin = 0 -> q = 0100, sout = 1, cnt = 1. Then ror -> q = 0010, sout = 0, cnt = 1. Then rol -> q = 0100, sout = 0.
- Clear and reserved: from q = 0100 with cnt = 1, mode = 111 -> everything unchanged. Then mode = 110 -> q = 0000, sout = 0, cnt = 0.
- Reset mid-operation: load 1111, apply 2 shl, then assert reset together with mode = 010 -> q = 1010, cnt = 0, sout = 0 on that edge.
